// File: rtl/pixel_writer.sv
// Alpha-tests ARGB8888 pixels, packs them to RGB565 and writes address-contiguous bursts.
// Optional per-pixel statistics counters are enabled with PIXEL_WRITER_STATS_EN.
module pixel_writer #(
    parameter int          DEPTH        = 16,
    parameter int          MAX_BURST    = 8,
    parameter logic [7:0]  ALPHA_THRESH = 8'd1,
    parameter int          STALL_MARGIN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [19:0] in_addr,
    input  logic [31:0] in_data,
    output logic        stall,
    output logic        overflow,
    output logic        wr_req,
    output logic [19:0] wr_addr,
    input  logic        wr_ack,
    output logic        wr_valid,
    output logic [15:0] wr_data,
    output logic        wr_last,
    input  logic        wr_ready,
    output logic [15:0] discard_cnt,
    output logic [15:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - STALL_MARGIN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_e;

    logic [19:0]   addr_mem_q [DEPTH];
    logic [15:0]   col_mem_q  [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] nxt_ptr;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q, state_d;
    logic [19:0]   wr_addr_q, wr_addr_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic          overflow_q, overflow_d;

    logic          alpha_low, push, drop, pop;
    logic          contig, last;
    logic [19:0]   head_addr, next_addr;
    logic [15:0]   pix565;
    logic          unused_bits;

    assign alpha_low   = in_data[31:24] < ALPHA_THRESH;
    assign push        = in_valid & ~alpha_low & (count_q != FULL);
    assign drop        = in_valid & ~alpha_low & (count_q == FULL);
    assign pix565      = {in_data[23:19], in_data[15:10], in_data[7:3]};
    assign unused_bits = ^{in_data[18:16], in_data[9:8], in_data[2:0]};

    assign nxt_ptr   = rd_ptr_q + AW'(1);
    assign head_addr = addr_mem_q[rd_ptr_q];
    assign next_addr = addr_mem_q[nxt_ptr];
    // 21-bit compare so the 0xFFFFF -> 0x00000 wrap breaks the burst
    assign contig    = {1'b0, next_addr} == ({1'b0, head_addr} + 21'd1);
    assign last      = (beat_cnt_q == LAST_BEAT) || (count_q == CW'(1)) || !contig;

    assign stall    = count_q >= STALL_LVL;
    assign overflow = overflow_q;
    assign wr_addr  = wr_addr_q;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= in_addr;
            col_mem_q[wr_ptr_q]  <= pix565;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        beat_cnt_d = beat_cnt_q;
        wr_req     = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = 16'd0;
        wr_last    = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    wr_addr_d  = head_addr;
                    beat_cnt_d = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                wr_req = 1'b1;
                if (wr_ack) state_d = DATA;
            end
            DATA: begin
                wr_valid = 1'b1;
                wr_data  = col_mem_q[rd_ptr_q];
                wr_last  = last;
                if (wr_ready && count_q != '0) begin
                    pop        = 1'b1;
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + CW'(push) - CW'(pop);
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_addr_q  <= '0;
            beat_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wr_addr_q  <= wr_addr_d;
            beat_cnt_q <= beat_cnt_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef PIXEL_WRITER_STATS_EN
    logic [15:0] discard_cnt_q, discard_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        discard_cnt_d = discard_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        if (in_valid && alpha_low && discard_cnt_q != 16'hFFFF)
            discard_cnt_d = discard_cnt_q + 16'd1;
        if (drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            discard_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            discard_cnt_q <= discard_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign discard_cnt = discard_cnt_q;
    assign drop_cnt    = drop_cnt_q;
`else
    assign discard_cnt = 16'd0;
    assign drop_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_pixel_writer.sv
// Randomized self-checking bench for pixel_writer against a burst-grouping model.
module tb_pixel_writer;

    localparam int DEPTH     = 16;
    localparam int MAX_BURST = 8;
    localparam int ALPHA     = 1;

    typedef struct packed {
        logic [19:0] addr;
        logic [31:0] argb;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [19:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic        stall, overflow, wr_req, wr_valid, wr_last;
    logic [19:0] wr_addr;
    logic [15:0] wr_data, discard_cnt, drop_cnt;
    logic        wr_ack = 1'b0;
    logic        wr_ready = 1'b0;

    pixel_writer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .stall(stall), .overflow(overflow),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
        .wr_ready(wr_ready),
        .discard_cnt(discard_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    logic [19:0] cmd_q[$];
    logic [16:0] beat_q[$];
    logic [19:0] exp_cmd[$];
    logic [16:0] exp_beat[$];
    int exp_discard, exp_drop;
    int tests_run, tests_failed;
    int proto_err;
    logic hold_v, req_pend;
    logic [16:0] hold_beat;

    // Bus monitor: records accepted commands and beats, counts handshake violations
    always @(negedge clk) begin
        if (rst) begin
            hold_v   = 1'b0;
            req_pend = 1'b0;
        end else begin
            if (hold_v && (!wr_valid || {wr_last, wr_data} !== hold_beat)) proto_err++;
            if (req_pend && !wr_req) proto_err++;
            if (wr_valid && wr_req) proto_err++;
            if (wr_req && wr_ack) cmd_q.push_back(wr_addr);
            if (wr_valid && wr_ready) beat_q.push_back({wr_last, wr_data});
            hold_v    = wr_valid && !wr_ready;
            hold_beat = {wr_last, wr_data};
            req_pend  = wr_req && !wr_ack;
        end
    end

    function automatic logic [15:0] rgb565(input logic [31:0] argb);
        int r, g, b;
        r = int'(argb[23:16]);
        g = int'(argb[15:8]);
        b = int'(argb[7:0]);
        return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
    endfunction

    // Filters, accounts for capacity (no pops during preload) and groups bursts
    function automatic void model(input pix_t px[$]);
        logic [19:0] acc_a[$];
        logic [15:0] acc_c[$];
        logic [16:0] t;
        int occ, run;
        exp_cmd.delete();
        exp_beat.delete();
        occ = 0;
        foreach (px[i]) begin
            if (int'(px[i].argb[31:24]) < ALPHA) begin
                if (exp_discard < 65535) exp_discard++;
            end else if (occ == DEPTH) begin
                if (exp_drop < 65535) exp_drop++;
            end else begin
                occ++;
                acc_a.push_back(px[i].addr);
                acc_c.push_back(rgb565(px[i].argb));
            end
        end
        run = 0;
        foreach (acc_a[i]) begin
            if (i == 0 || run == MAX_BURST || int'(acc_a[i]) != int'(acc_a[i-1]) + 1) begin
                if (i > 0) begin
                    t = exp_beat.pop_back();
                    t[16] = 1'b1;
                    exp_beat.push_back(t);
                end
                exp_cmd.push_back(acc_a[i]);
                run = 0;
            end
            exp_beat.push_back({1'b0, acc_c[i]});
            run++;
        end
        if (acc_a.size() > 0) begin
            t = exp_beat.pop_back();
            t[16] = 1'b1;
            exp_beat.push_back(t);
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        wr_ack = 1'b0;
        wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_discard = 0;
        exp_drop = 0;
        cmd_q.delete();
        beat_q.delete();
    endtask

    task automatic push_all(input pix_t px[$]);
        foreach (px[i]) begin
            in_valid = 1'b1;
            in_addr  = px[i].addr;
            in_data  = px[i].argb;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n, input bit rnd);
        for (int c = 0; c < 600 && beat_q.size() < n; c++) begin
            wr_ack   = rnd ? 1'($urandom) : 1'b1;
            wr_ready = rnd ? ($urandom % 4 != 0) : 1'b1;
            @(posedge clk);
            #1;
        end
        wr_ack = 1'b1;
        wr_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        wr_ack = 1'b0;
        wr_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'($urandom);
            in_addr  = 20'($urandom);
            in_data  = $urandom;
            wr_ack   = 1'($urandom);
            wr_ready = 1'($urandom);
            @(posedge clk);
            #1;
            tests_run++;
            if ({stall, overflow, wr_req, wr_addr, wr_valid, wr_data, wr_last,
                 discard_cnt, drop_cnt} !== '0) begin
                tests_failed++;
                $display("FAIL reset_hold: outputs %h want 0",
                         {stall, overflow, wr_req, wr_addr, wr_valid, wr_data, wr_last});
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
        wr_ack = 1'b0;
        wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if ({stall, overflow, wr_req, wr_addr, wr_valid, wr_data, wr_last,
                 discard_cnt, drop_cnt} !== '0) begin
                tests_failed++;
                $display("FAIL reset_release: outputs %h want 0",
                         {stall, overflow, wr_req, wr_addr, wr_valid, wr_data, wr_last});
            end
        end
        exp_discard = 0;
        exp_drop = 0;
        cmd_q.delete();
        beat_q.delete();
    endtask

    task automatic test_contiguous();
        pix_t px[$];
        do_reset();
        for (int i = 0; i < 4; i++) px.push_back({20'h00100 + 20'(i), 32'hFFFF0000});
        model(px);
        wr_ack = 1'b1;
        wr_ready = 1'b1;
        foreach (px[i]) begin
            in_valid = 1'b1;
            in_addr  = px[i].addr;
            in_data  = px[i].argb;
            @(posedge clk);
            #1;
            if (i == 0) begin
                tests_run++;
                if (wr_req !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL lat_req_early: got %b want 0", wr_req);
                end
            end
            if (i == 1) begin
                tests_run++;
                if (wr_req !== 1'b1 || wr_addr !== 20'h00100) begin
                    tests_failed++;
                    $display("FAIL lat_req: req %b addr %h want 1 00100", wr_req, wr_addr);
                end
            end
        end
        in_valid = 1'b0;
        drain(exp_beat.size(), 1'b0);
        tests_run++;
        if (cmd_q.size() != exp_cmd.size()) begin
            tests_failed++;
            $display("FAIL contig_ncmd: got %0d want %0d", cmd_q.size(), exp_cmd.size());
        end
        foreach (exp_cmd[i]) if (i < cmd_q.size()) begin
            tests_run++;
            if (cmd_q[i] !== exp_cmd[i]) begin
                tests_failed++;
                $display("FAIL contig_addr[%0d]: got %h want %h", i, cmd_q[i], exp_cmd[i]);
            end
        end
        tests_run++;
        if (beat_q.size() != exp_beat.size()) begin
            tests_failed++;
            $display("FAIL contig_nbeat: got %0d want %0d", beat_q.size(), exp_beat.size());
        end
        foreach (exp_beat[i]) if (i < beat_q.size()) begin
            tests_run++;
            if (beat_q[i] !== exp_beat[i]) begin
                tests_failed++;
                $display("FAIL contig_beat[%0d]: got %h want %h", i, beat_q[i], exp_beat[i]);
            end
        end
    endtask

    task automatic test_preload(input string name, input pix_t px[$]);
        cmd_q.delete();
        beat_q.delete();
        wr_ack = 1'b0;
        wr_ready = 1'b0;
        model(px);
        push_all(px);
        drain(exp_beat.size(), 1'b1);
        tests_run++;
        if (cmd_q.size() != exp_cmd.size()) begin
            tests_failed++;
            $display("FAIL %s_ncmd: got %0d want %0d", name, cmd_q.size(), exp_cmd.size());
        end
        foreach (exp_cmd[i]) if (i < cmd_q.size()) begin
            tests_run++;
            if (cmd_q[i] !== exp_cmd[i]) begin
                tests_failed++;
                $display("FAIL %s_addr[%0d]: got %h want %h", name, i, cmd_q[i], exp_cmd[i]);
            end
        end
        tests_run++;
        if (beat_q.size() != exp_beat.size()) begin
            tests_failed++;
            $display("FAIL %s_nbeat: got %0d want %0d", name, beat_q.size(), exp_beat.size());
        end
        foreach (exp_beat[i]) if (i < beat_q.size()) begin
            tests_run++;
            if (beat_q[i] !== exp_beat[i]) begin
                tests_failed++;
                $display("FAIL %s_beat[%0d]: got %h want %h", name, i, beat_q[i], exp_beat[i]);
            end
        end
    endtask

    task automatic test_split();
        pix_t px[$];
        for (int i = 0; i < 10; i++) px.push_back({20'h00200 + 20'(i), 32'hFF00FF00});
        test_preload("split", px);
    endtask

    task automatic test_wrap();
        pix_t px[$];
        px.push_back({20'h00010, 32'hFF123456});
        px.push_back({20'h00020, 32'hFF80C040});
        px.push_back({20'hFFFFF, 32'hFFFFFFFF});
        px.push_back({20'h00000, 32'hFF0000FF});
        test_preload("wrap", px);
    endtask

    task automatic test_alpha();
        pix_t px[$];
        int want;
        cmd_q.delete();
        beat_q.delete();
        px.push_back({20'h00005, 32'h00FFFFFF});
        model(px);
        wr_ack = 1'b1;
        wr_ready = 1'b1;
        push_all(px);
        repeat (10) @(posedge clk);
        #1;
        tests_run++;
        if (cmd_q.size() != 0 || beat_q.size() != 0) begin
            tests_failed++;
            $display("FAIL alpha_write: cmds %0d beats %0d want 0 0", cmd_q.size(), beat_q.size());
        end
`ifdef PIXEL_WRITER_STATS_EN
        want = exp_discard;
`else
        want = 0;
`endif
        tests_run++;
        if (int'(discard_cnt) != want) begin
            tests_failed++;
            $display("FAIL alpha_cnt: got %0d want %0d", discard_cnt, want);
        end
        wr_ack = 1'b0;
        wr_ready = 1'b0;
    endtask

    task automatic test_random();
        int want;
        for (int r = 0; r < 6; r++) begin
            pix_t px[$];
            logic [19:0] a;
            logic [31:0] d;
            int n;
            n = $urandom_range(1, DEPTH);
            a = (r == 2) ? 20'hFFFFC : 20'($urandom);
            for (int i = 0; i < n; i++) begin
                d = $urandom;
                if ($urandom % 5 == 0) d[31:24] = 8'h00;
                px.push_back({a, d});
                a = ($urandom % 4 != 0) ? a + 20'd1 : 20'($urandom);
            end
            test_preload("rand", px);
`ifdef PIXEL_WRITER_STATS_EN
            want = exp_discard;
`else
            want = 0;
`endif
            tests_run++;
            if (int'(discard_cnt) != want) begin
                tests_failed++;
                $display("FAIL rand_discard: got %0d want %0d", discard_cnt, want);
            end
        end
    endtask

    task automatic test_overflow();
        pix_t px[$];
        int want, occ;
        do_reset();
        for (int i = 0; i < 20; i++)
            px.push_back({20'h00300 + 20'(i), {8'hFF, 24'($urandom)}});
        model(px);
        foreach (px[i]) begin
            in_valid = 1'b1;
            in_addr  = px[i].addr;
            in_data  = px[i].argb;
            @(posedge clk);
            #1;
            occ = (i + 1 > DEPTH) ? DEPTH : i + 1;
            tests_run++;
            if (stall !== (occ >= DEPTH - 4)) begin
                tests_failed++;
                $display("FAIL ovf_stall[%0d]: got %b want %b", i, stall, occ >= DEPTH - 4);
            end
            if (i == DEPTH - 1) begin
                tests_run++;
                if (overflow !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL ovf_early: got %b want 0", overflow);
                end
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (overflow !== (exp_drop > 0)) begin
            tests_failed++;
            $display("FAIL ovf_flag: got %b want %b", overflow, exp_drop > 0);
        end
`ifdef PIXEL_WRITER_STATS_EN
        want = exp_drop;
`else
        want = 0;
`endif
        tests_run++;
        if (int'(drop_cnt) != want) begin
            tests_failed++;
            $display("FAIL ovf_dropcnt: got %0d want %0d", drop_cnt, want);
        end
        wr_ack = 1'b1;
        wr_ready = 1'b1;
        for (int c = 0; c < 100 && beat_q.size() < 11; c++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if ({wr_valid, wr_req, wr_last, overflow, stall} !== 5'b0) begin
            tests_failed++;
            $display("FAIL ovf_midrst: valid/req/last/ovf/stall %b want 00000",
                     {wr_valid, wr_req, wr_last, overflow, stall});
        end
        rst = 1'b0;
        exp_drop = 0;
        exp_discard = 0;
        repeat (10) @(posedge clk);
        #1;
        tests_run++;
        if (cmd_q.size() != 2 || beat_q.size() != 11) begin
            tests_failed++;
            $display("FAIL ovf_after_rst: cmds %0d beats %0d want 2 11", cmd_q.size(), beat_q.size());
        end
        for (int i = 0; i < 2 && i < cmd_q.size(); i++) begin
            tests_run++;
            if (cmd_q[i] !== exp_cmd[i]) begin
                tests_failed++;
                $display("FAIL ovf_addr[%0d]: got %h want %h", i, cmd_q[i], exp_cmd[i]);
            end
        end
        for (int i = 0; i < 11 && i < beat_q.size(); i++) begin
            tests_run++;
            if (beat_q[i] !== exp_beat[i]) begin
                tests_failed++;
                $display("FAIL ovf_beat[%0d]: got %h want %h", i, beat_q[i], exp_beat[i]);
            end
        end
        wr_ack = 1'b0;
        wr_ready = 1'b0;
    endtask

    task automatic test_protocol();
        tests_run++;
        if (proto_err != 0) begin
            tests_failed++;
            $display("FAIL protocol: got %0d violations want 0", proto_err);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        proto_err = 0;
        exp_discard = 0;
        exp_drop = 0;
        test_reset();
        test_contiguous();
        test_split();
        test_wrap();
        test_alpha();
        test_random();
        test_overflow();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
